// File: rtl/core_msg_rx_pkg.sv
// core_msg_rx_pkg
// Shared definitions for the per-core scheduler message receiver:
//   - r0 preload geometry (words per task, byte width of one core's r0)
//   - receiver FSM state encoding
package core_msg_rx_pkg;

  localparam int R0_WORD_COUNT = 8;
  localparam int R0_BYTE_W     = 8;

  typedef enum logic [1:0] {
    CRX_IDLE = 2'd0,
    CRX_SEL  = 2'd1,
    CRX_R0   = 2'd2,
    CRX_RUN  = 2'd3
  } crx_state_e;

  // Number of loading flags raised in one cycle; more than one is a
  // protocol violation and the word is discarded.
  function automatic logic [2:0] flag_count(input logic a, input logic b,
                                            input logic c, input logic d);
    return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  endfunction

endpackage

// File: rtl/core_msg_rx_instr_fifo.sv
// instr_fifo
// Synchronous FIFO with registered read data.
//   clk, reset      : clock, synchronous active-high reset
//   flush_i         : drop all contents (pointers back to 0)
//   wr_en_i/data_i  : push; accepted when not full, or when full together
//                     with a successful pop (pop happens first)
//   rd_en_i         : pop request; ignored while empty
//   rd_data_o       : popped word, valid the cycle after the request
//   rd_valid_o      : rd_data_o holds a freshly popped word
//   full_o/empty_o  : occupancy flags from registered pointers
//   free_o          : number of free entries
module instr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       rd_valid_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     free_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] DEPTH_CNT = AW1'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             do_rd;
  logic             do_wr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign free_o  = DEPTH_CNT - (wr_ptr_q - rd_ptr_q);

  assign do_rd = rd_en_i && !empty_o && !flush_i;
  // A pop in the same cycle frees the slot the write lands in.
  assign do_wr = wr_en_i && (!full_o || do_rd) && !flush_i;

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= do_rd;
      if (do_rd) begin
        rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
    end
  end

  // Storage kept in its own reset-free block so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/core_msg_rx.sv
// core_msg_rx
// Per-core receiver for the scheduler->core message bus. Decodes the flagged
// word stream (core mask, r0-init mask, r0 data words, instructions), keeps
// this core's r0 byte and queues its instructions for the pipeline.
//   clk, reset                 : clock, synchronous active-high reset
//   mess_to_core + *_loading   : flagged message word from the scheduler
//   core_reading / core_ready  : flow control and idle status to scheduler
//   r0_value / r0_valid        : this core's r0 initial value
//   task_start                 : one-cycle pulse, execution may begin
//   ibuf_rd_* / ibuf_empty     : instruction FIFO pop interface
//   exec_done                  : pipeline finished the task
//   proto_err                  : sticky protocol-violation flag
module core_msg_rx
  import core_msg_rx_pkg::*;
#(
  parameter int CORE_ID    = 0,
  parameter int BUS_WIDTH  = 16,
  parameter int INSTR_SIZE = 16,
  parameter int IBUF_DEPTH = 64,
  parameter int R0_WORDS   = R0_WORD_COUNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_WIDTH-1:0]  mess_to_core,
  input  logic                  core_mask_loading,
  input  logic                  r0_mask_loading,
  input  logic                  r0_loading,
  input  logic                  instr_loading,
  output logic                  core_reading,
  output logic                  core_ready,
  output logic [7:0]            r0_value,
  output logic                  r0_valid,
  output logic                  task_start,
  input  logic                  ibuf_rd_en,
  output logic [INSTR_SIZE-1:0] ibuf_rd_data,
  output logic                  ibuf_rd_valid,
  output logic                  ibuf_empty,
  input  logic                  exec_done,
  output logic                  proto_err
);

  localparam int          FW       = $clog2(IBUF_DEPTH) + 1;
  localparam logic [FW-1:0] MIN_FREE = FW'(2);
  localparam logic [2:0]  R0_SLOT  = 3'(CORE_ID >> 1);
  localparam logic [2:0]  R0_LAST  = 3'(R0_WORDS - 1);
  localparam int          BYTE_LSB = (CORE_ID % 2) * R0_BYTE_W;

  crx_state_e     state_q;
  crx_state_e     eff_state;
  logic [2:0]     r0_idx_q;
  logic           r0_init_q;
  logic [7:0]     r0_value_q;
  logic           r0_valid_q;
  logic           task_start_q;
  logic           proto_err_q;

  logic [2:0]     flag_sum;
  logic           single_flag;
  logic           cm_word, rm_word, r0_word, in_word;
  logic           own_bit;
  logic           run_exit;
  logic           fifo_wr;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FW-1:0]  fifo_free;
  logic           fifo_overflow;
  logic           err_event;

  assign flag_sum    = flag_count(core_mask_loading, r0_mask_loading,
                                  r0_loading, instr_loading);
  assign single_flag = (flag_sum == 3'd1);
  assign cm_word     = core_mask_loading && single_flag;
  assign rm_word     = r0_mask_loading   && single_flag;
  assign r0_word     = r0_loading        && single_flag;
  assign in_word     = instr_loading     && single_flag;
  assign own_bit     = mess_to_core[CORE_ID];

  // exec_done returns to IDLE on this edge, and the word sharing the cycle
  // is judged as if already in IDLE.
  assign run_exit  = (state_q == CRX_RUN) && exec_done;
  assign eff_state = run_exit ? CRX_IDLE : state_q;

  // The first instruction in R0 also starts the task, so it is queued too.
  assign fifo_wr       = in_word && (eff_state == CRX_RUN || eff_state == CRX_R0);
  assign fifo_overflow = fifo_wr && fifo_full && !(ibuf_rd_en && !fifo_empty);

  assign err_event = (flag_sum > 3'd1)
                   || (cm_word && own_bit && eff_state != CRX_IDLE)
                   || (rm_word && (eff_state == CRX_R0 || eff_state == CRX_RUN))
                   || (exec_done && state_q != CRX_RUN)
                   || fifo_overflow;

  instr_fifo #(
    .WIDTH (INSTR_SIZE),
    .DEPTH (IBUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (run_exit),
    .wr_en_i    (fifo_wr),
    .wr_data_i  (mess_to_core[INSTR_SIZE-1:0]),
    .rd_en_i    (ibuf_rd_en),
    .rd_data_o  (ibuf_rd_data),
    .rd_valid_o (ibuf_rd_valid),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .free_o     (fifo_free)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CRX_IDLE;
      r0_idx_q     <= '0;
      r0_init_q    <= 1'b0;
      r0_value_q   <= '0;
      r0_valid_q   <= 1'b0;
      task_start_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      task_start_q <= 1'b0;
      state_q      <= eff_state;
      if (err_event) begin
        proto_err_q <= 1'b1;
      end
      if (run_exit) begin
        r0_valid_q <= 1'b0;
      end
      case (eff_state)
        CRX_IDLE: begin
          if (cm_word && own_bit) begin
            state_q    <= CRX_SEL;
            r0_valid_q <= 1'b0;
            r0_idx_q   <= '0;
          end
        end
        CRX_SEL: begin
          if (rm_word) begin
            r0_init_q <= own_bit;
            state_q   <= CRX_R0;
          end
        end
        CRX_R0: begin
          if (r0_word) begin
            r0_idx_q <= r0_idx_q + 1'b1;
            if (r0_idx_q == R0_SLOT && r0_init_q) begin
              r0_value_q <= mess_to_core[BYTE_LSB +: R0_BYTE_W];
              r0_valid_q <= 1'b1;
            end
            if (r0_idx_q == R0_LAST) begin
              state_q      <= CRX_RUN;
              task_start_q <= 1'b1;
            end
          end else if (in_word) begin
            state_q      <= CRX_RUN;
            task_start_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Two free slots are needed in RUN: the scheduler's registered output
  // already has one more word on its way when it sees core_reading drop.
  assign core_reading = (state_q != CRX_RUN) || (fifo_free >= MIN_FREE);
  assign core_ready   = (state_q == CRX_IDLE);
  assign r0_value     = r0_value_q;
  assign r0_valid     = r0_valid_q;
  assign task_start   = task_start_q;
  assign ibuf_empty   = fifo_empty;
  assign proto_err    = proto_err_q;

endmodule
